ramenable_multicfg: RTL and testbench

//  Multi-configuration RAM/bus enable lookup for the 6502-side address bus.

---
 rtl/ramenable_multicfg.sv | 190 +++++++++++++++++++
 tb/tb_ramenable_multicfg.sv | 317 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ramenable_multicfg.sv
// ramenable_multicfg
//   RAM/bus enable lookup for the 6502-side address bus. Holds NUM_CFGS
//   independent enable maps. Each map is indexed by {rwbar, address high bits}.
//   After reset, a sequencer fills the whole table with DEFAULT_ENT, one entry
//   per cycle. During that time ready is low. Config switches requested with
//   cfg_req wait until phi2 is low, so the active map never changes in the
//   middle of a CPU access.
//
// Optional feature: define RAMEN_WRITE_TRAP_EN to add a write-trap monitor
//   (outputs trap_valid/trap_addr, input trap_clr).
//
// Ports
//   fpga_clk          system clock, all state on rising edge
//   reset             synchronous, active-high
//   address           CPU address
//   phi2              CPU phase-2 clock (sampled level)
//   rwbar             1 = read, 0 = write
//   mreq              memory request, active-high
//   cs_ram            phi2 & ram_en & mreq & ready
//   cs_bus            (phi2 & bus_en) | !mreq
//   we                phi2 & !rwbar
//   table_we          table write strobe (ignored while clearing)
//   table_write_addr  {cfg, rwbar, region}
//   table_val         {ram_en, bus_en}
//   cfg_req           1-cycle pulse requesting a switch to cfg_next
//   cfg_next          requested config
//   cfg_ack           1-cycle pulse when the switch takes effect
//   active_cfg        config currently used for lookup
//   ready             low while the table is being cleared
//   trap_valid        (trap build) sticky write-to-disabled-region flag
//   trap_addr         (trap build) address of the first trapped write
//   trap_clr          (trap build) clears trap_valid
module ramenable_multicfg #(
    parameter int         ADDR_WIDTH  = 16,
    parameter int         GRAN_SIZE   = 256,
    parameter int         NUM_CFGS    = 4,
    parameter logic [1:0] DEFAULT_ENT = 2'b01,
    localparam int        GB          = $clog2(GRAN_SIZE),
    localparam int        RB          = ADDR_WIDTH - GB,
    localparam int        CB          = $clog2(NUM_CFGS),
    localparam int        TA          = CB + 1 + RB
) (
    input  logic                  fpga_clk,
    input  logic                  reset,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic                  phi2,
    input  logic                  rwbar,
    input  logic                  mreq,
    output logic                  cs_ram,
    output logic                  cs_bus,
    output logic                  we,
    input  logic                  table_we,
    input  logic [TA-1:0]         table_write_addr,
    input  logic [1:0]            table_val,
    input  logic                  cfg_req,
    input  logic [CB-1:0]         cfg_next,
    output logic                  cfg_ack,
    output logic [CB-1:0]         active_cfg,
    output logic                  ready
`ifdef RAMEN_WRITE_TRAP_EN
    ,
    output logic                  trap_valid,
    output logic [ADDR_WIDTH-1:0] trap_addr,
    input  logic                  trap_clr
`endif
);

    localparam int TBL_DEPTH = 2 ** TA;

    typedef enum logic {ST_CLEAR, ST_RUN} state_t;

    state_t          r_state;
    state_t          w_state_next;

    logic [1:0]      r_table [0:TBL_DEPTH-1];
    logic [TA-1:0]   r_clr_idx;
    logic [1:0]      r_outval;
    logic [CB-1:0]   r_active_cfg;
    logic            r_pend;
    logic [CB-1:0]   r_pend_cfg;
    logic            r_cfg_ack;
    logic            r_ready;

    logic [TA-1:0]   w_lookup_idx;
    logic            w_tbl_we;
    logic [TA-1:0]   w_tbl_waddr;
    logic [1:0]      w_tbl_wdata;
    logic            w_unused_addr;

    assign w_lookup_idx  = {r_active_cfg, rwbar, address[ADDR_WIDTH-1 -: RB]};
    assign w_unused_addr = ^address[GB-1:0];

    // State register
    always_ff @(posedge fpga_clk) begin
        if (reset) begin
            r_state <= ST_CLEAR;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next state and the single table write port. The clear sequencer and
    // host writes share the port; host writes are ignored while clearing.
    always_comb begin
        w_state_next = r_state;
        w_tbl_we     = 1'b0;
        w_tbl_waddr  = table_write_addr;
        w_tbl_wdata  = table_val;
        case (r_state)
            ST_CLEAR: begin
                w_tbl_we    = !reset;
                w_tbl_waddr = r_clr_idx;
                w_tbl_wdata = DEFAULT_ENT;
                if (r_clr_idx == {TA{1'b1}}) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                w_tbl_we = table_we && !reset;
            end
            default: begin
                w_state_next = ST_CLEAR;
            end
        endcase
    end

    always_ff @(posedge fpga_clk) begin
        if (w_tbl_we) begin
            r_table[w_tbl_waddr] <= w_tbl_wdata;
        end
    end

    always_ff @(posedge fpga_clk) begin
        if (reset) begin
            r_clr_idx    <= '0;
            r_outval     <= DEFAULT_ENT;
            r_active_cfg <= '0;
            r_pend       <= 1'b0;
            r_pend_cfg   <= '0;
            r_cfg_ack    <= 1'b0;
            r_ready      <= 1'b0;
        end else begin
            r_ready   <= (w_state_next == ST_RUN);
            r_cfg_ack <= 1'b0;
            if (r_state == ST_CLEAR) begin
                r_clr_idx <= r_clr_idx + 1'b1;
                r_outval  <= DEFAULT_ENT;
            end else begin
                // A host write takes the cycle; the lookup result holds.
                if (!table_we) begin
                    r_outval <= r_table[w_lookup_idx];
                end
                if (r_pend && !phi2) begin
                    r_active_cfg <= r_pend_cfg;
                    r_pend       <= 1'b0;
                    r_cfg_ack    <= 1'b1;
                end
                // Written after the apply, so a request arriving in the same
                // cycle stays pending for the next phi2-low window.
                if (cfg_req) begin
                    r_pend     <= 1'b1;
                    r_pend_cfg <= cfg_next;
                end
            end
        end
    end

`ifdef RAMEN_WRITE_TRAP_EN
    always_ff @(posedge fpga_clk) begin
        if (reset) begin
            trap_valid <= 1'b0;
            trap_addr  <= '0;
        end else if (trap_clr) begin
            trap_valid <= 1'b0;
        end else if (r_state == ST_RUN && phi2 && mreq && !rwbar &&
                     r_outval == 2'b00 && !trap_valid) begin
            trap_valid <= 1'b1;
            trap_addr  <= address;
        end
    end
`endif

    assign cs_ram     = phi2 & r_outval[1] & mreq & r_ready;
    assign cs_bus     = (phi2 & r_outval[0]) | !mreq;
    assign we         = phi2 & !rwbar;
    assign cfg_ack    = r_cfg_ack;
    assign active_cfg = r_active_cfg;
    assign ready      = r_ready;

endmodule

// File: tb/tb_ramenable_multicfg.sv
// Testbench for ramenable_multicfg with default parameters. It uses a
// behavioural model that computes table indices arithmetically, a table of
// directed vectors, hand-written corner sequences, and a randomized phase.
module tb_ramenable_multicfg;

    localparam int AW   = 16;
    localparam int GRAN = 256;
    localparam int NREG = (2 ** AW) / GRAN;
    localparam int NCFG = 4;
    localparam int NENT = NCFG * 2 * NREG;
    localparam logic [1:0] DEF = 2'b01;

    logic        fpga_clk = 1'b0;
    logic        reset, phi2, rwbar, mreq, table_we, cfg_req;
    logic [15:0] address;
    logic [10:0] table_write_addr;
    logic [1:0]  table_val, cfg_next;
    logic        cs_ram, cs_bus, we, cfg_ack, ready;
    logic [1:0]  active_cfg;
`ifdef RAMEN_WRITE_TRAP_EN
    logic        trap_valid, trap_clr;
    logic [15:0] trap_addr;
`endif

    ramenable_multicfg #(.ADDR_WIDTH(AW), .GRAN_SIZE(GRAN), .NUM_CFGS(NCFG), .DEFAULT_ENT(DEF)) dut (
        .fpga_clk(fpga_clk), .reset(reset), .address(address), .phi2(phi2),
        .rwbar(rwbar), .mreq(mreq), .cs_ram(cs_ram), .cs_bus(cs_bus), .we(we),
        .table_we(table_we), .table_write_addr(table_write_addr),
        .table_val(table_val), .cfg_req(cfg_req), .cfg_next(cfg_next),
        .cfg_ack(cfg_ack), .active_cfg(active_cfg), .ready(ready)
`ifdef RAMEN_WRITE_TRAP_EN
        , .trap_valid(trap_valid), .trap_addr(trap_addr), .trap_clr(trap_clr)
`endif
    );

    always #5 fpga_clk = ~fpga_clk;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    logic [1:0] m_tbl [0:NENT-1];
    logic [1:0] m_out;
    int         m_cfg, m_pcfg, m_cnt;
    bit         m_pend, m_ack, m_ready, m_clearing;
    bit         m_tv;
    logic [15:0] m_ta;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int idx;
        logic [1:0] nout;
        bit ntv;
        logic [15:0] nta;
        bit tclr;
`ifdef RAMEN_WRITE_TRAP_EN
        tclr = trap_clr;
`else
        tclr = 1'b0;
`endif
        ntv = m_tv;
        nta = m_ta;
        if (reset) begin
            m_clearing = 1; m_cnt = 0; m_out = DEF; m_cfg = 0; m_pcfg = 0;
            m_pend = 0; m_ack = 0; m_ready = 0; m_tv = 0; m_ta = '0;
            return;
        end
        if (tclr) ntv = 0;
        if (m_clearing) begin
            m_tbl[m_cnt] = DEF;
            m_cnt++;
            if (m_cnt == NENT) begin
                m_clearing = 0;
                m_ready = 1;
            end
            m_ack = 0;
            m_out = DEF;
        end else begin
            if (!tclr && phi2 && mreq && !rwbar && m_out == 2'b00 && !m_tv) begin
                ntv = 1;
                nta = address;
            end
            idx  = m_cfg * 2 * NREG + int'(rwbar) * NREG + int'(address) / GRAN;
            nout = table_we ? m_out : m_tbl[idx];
            if (table_we) m_tbl[int'(table_write_addr)] = table_val;
            m_out = nout;
            m_ack = m_pend && !phi2;
            if (m_ack) begin
                m_cfg  = m_pcfg;
                m_pend = 0;
            end
            if (cfg_req) begin
                m_pend = 1;
                m_pcfg = int'(cfg_next);
            end
        end
        m_tv = ntv;
        m_ta = nta;
    endtask

    task automatic tick();
        @(posedge fpga_clk);
        model_step();
        #1;
        chk("ready", ready, m_ready);
        chk("cfg_ack", cfg_ack, m_ack);
        chk("active_cfg", active_cfg, m_cfg);
        chk("cs_ram", cs_ram, phi2 & m_out[1] & mreq & m_ready);
        chk("cs_bus", cs_bus, (phi2 & m_out[0]) | !mreq);
        chk("we", we, phi2 & !rwbar);
`ifdef RAMEN_WRITE_TRAP_EN
        chk("trap_valid", trap_valid, m_tv);
        if (m_tv) chk("trap_addr", trap_addr, m_ta);
`endif
    endtask

    // Runs until ready rises; returns the number of cycles it took.
    task automatic wait_clear(input bit noisy, output int cycles);
        cycles = 0;
        for (int i = 0; i < 3000; i++) begin
            phi2  = 1'($urandom_range(0, 1));
            mreq  = 1'($urandom_range(0, 1));
            rwbar = 1'($urandom_range(0, 1));
            address = 16'($urandom);
            if (noisy) begin
                table_we = 1'($urandom_range(0, 1));
                table_write_addr = 11'($urandom);
                table_val = 2'($urandom);
                cfg_req = 1'($urandom_range(0, 1));
                cfg_next = 2'($urandom);
            end
            tick();
            cycles++;
            if (ready) break;
        end
        table_we = 0;
        cfg_req  = 0;
    endtask

    typedef struct {
        logic [10:0] waddr;
        logic [1:0]  wval;
        logic [15:0] addr;
        logic        rw, mq, ph;
        logic        e_ram, e_bus, e_we;
    } vec_t;

    vec_t vt [5];
    int   cyc;

    initial begin
        vt[0] = '{11'h1C0, 2'b10, 16'hC012, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vt[1] = '{11'h012, 2'b11, 16'h1234, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        vt[2] = '{11'h155, 2'b00, 16'h5500, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        vt[3] = '{11'h1FF, 2'b01, 16'hFF00, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
        vt[4] = '{11'h377, 2'b10, 16'h7700, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};

        reset = 1; phi2 = 0; rwbar = 1; mreq = 1; address = '0;
        table_we = 0; table_write_addr = '0; table_val = '0;
        cfg_req = 0; cfg_next = '0;
`ifdef RAMEN_WRITE_TRAP_EN
        trap_clr = 0;
`endif
        #2;
        tick();
        chk("reset_ready", ready, 0);
        chk("reset_cfg", active_cfg, 0);

        // Clear takes 2048 cycles after reset release.
        reset = 0;
        wait_clear(1'b0, cyc);
        chk("clear_len", cyc, NENT);

        // Directed vectors: write, then look up with the write strobe dropped.
        foreach (vt[k]) begin
            address = vt[k].addr; rwbar = vt[k].rw; mreq = vt[k].mq; phi2 = vt[k].ph;
            table_we = 1; table_write_addr = vt[k].waddr; table_val = vt[k].wval;
            tick();
            table_we = 0;
            tick();
            tick();
            chk($sformatf("vec%0d_cs_ram", k), cs_ram, vt[k].e_ram);
            chk($sformatf("vec%0d_cs_bus", k), cs_bus, vt[k].e_bus);
            chk($sformatf("vec%0d_we", k), we, vt[k].e_we);
        end

        // A write to the entry being looked up holds outval for one cycle.
        address = 16'h4000; rwbar = 1; mreq = 1; phi2 = 1;
        table_we = 1; table_write_addr = 11'h140; table_val = 2'b10;
        tick();
        table_we = 0;
        tick();
        chk("wr_pre_ram", cs_ram, 1);
        table_we = 1; table_val = 2'b01;
        tick();
        chk("wr_hold_ram", cs_ram, 1);
        chk("wr_hold_bus", cs_bus, 0);
        table_we = 0;
        tick();
        chk("wr_new_ram", cs_ram, 0);
        chk("wr_new_bus", cs_bus, 1);

        // A config switch waits for phi2 to be low.
        phi2 = 1; cfg_req = 1; cfg_next = 2'd2;
        tick();
        cfg_req = 0;
        tick();
        chk("sw_wait_ack", cfg_ack, 0);
        chk("sw_wait_cfg", active_cfg, 0);
        phi2 = 0;
        tick();
        chk("sw_ack", cfg_ack, 1);
        chk("sw_cfg", active_cfg, 2);
        tick();
        chk("sw_ack_pulse", cfg_ack, 0);

        // A request in the same cycle as an apply stays pending. The bench
        // requests 1, 3, then 3 again, which is the current config.
        phi2 = 1; cfg_req = 1; cfg_next = 2'd1;
        tick();
        phi2 = 0; cfg_next = 2'd3;
        tick();
        chk("sw2_ack", cfg_ack, 1);
        chk("sw2_cfg", active_cfg, 1);
        cfg_req = 0;
        tick();
        chk("sw3_cfg", active_cfg, 3);
        cfg_req = 1;
        tick();
        cfg_req = 0;
        tick();
        chk("sw_same_ack", cfg_ack, 1);
        chk("sw_same_cfg", active_cfg, 3);
        phi2 = 1; cfg_req = 1; cfg_next = 2'd2;
        tick();
        cfg_req = 0; phi2 = 0;
        tick();
        chk("sw4_cfg", active_cfg, 2);

`ifdef RAMEN_WRITE_TRAP_EN
        // A write-trap sequence on cfg 2, with region 0xD0 disabled for writes.
        address = 16'hE000; rwbar = 1; phi2 = 1; mreq = 1;
        tick();
        table_we = 1; table_write_addr = {2'd2, 1'b0, 8'hD0}; table_val = 2'b00;
        tick();
        table_we = 0; address = 16'hD000; rwbar = 0;
        tick();
        tick();
        chk("trap_set", trap_valid, 1);
        chk("trap_addr", trap_addr, 16'hD000);
        address = 16'hD055;
        tick();
        tick();
        chk("trap_sticky", trap_addr, 16'hD000);
        trap_clr = 1;
        tick();
        chk("trap_clr", trap_valid, 0);
        trap_clr = 0;
        tick();
        chk("trap_reset", trap_valid, 1);
        chk("trap_addr2", trap_addr, 16'hD055);
`endif

        // Randomized traffic concentrated on four regions.
        for (int i = 0; i < 600; i++) begin
            phi2  = 1'($urandom_range(0, 1));
            mreq  = ($urandom_range(0, 7) != 0);
            rwbar = 1'($urandom_range(0, 1));
            address = {8'($urandom_range(0, 3)), 8'($urandom)};
            table_we = ($urandom_range(0, 3) == 0);
            table_write_addr = {2'($urandom), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 3))};
            table_val = 2'($urandom);
            cfg_req = ($urandom_range(0, 7) == 0);
            cfg_next = 2'($urandom);
`ifdef RAMEN_WRITE_TRAP_EN
            trap_clr = ($urandom_range(0, 15) == 0);
`endif
            tick();
        end
        table_we = 0; cfg_req = 0;
`ifdef RAMEN_WRITE_TRAP_EN
        trap_clr = 0;
`endif

        // Reset at clear index 500 restarts the full clear. Writes and config
        // requests issued during the clear must have no effect.
        reset = 1;
        tick();
        reset = 0;
        for (int i = 0; i < 500; i++) tick();
        reset = 1;
        tick();
        chk("midclr_ready", ready, 0);
        reset = 0;
        wait_clear(1'b1, cyc);
        chk("midclr_len", cyc, NENT);
        chk("midclr_cfg", active_cfg, 0);
        for (int i = 0; i < 40; i++) begin
            phi2 = 1'($urandom_range(0, 1));
            rwbar = 1'($urandom_range(0, 1));
            mreq = 1;
            address = 16'($urandom);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
